trap_ctrl: RTL and testbench

Machine-mode trap sequencer between the commit stage and the CSR file. Accepts synchronous exceptions, `mret`, and pending machine interrupts at an instruction boundary, then runs four steps in order: drain the pipeline, update the trap CSRs, update the privilege level, redirect fetch. It owns the current privilege register. It drives write data for `mepc`/`mcause`/`mtval`/`mstatus` using the `csr_pkg` layouts and cause codes.

---
 rtl/csr_pkg.sv | 45 ++++
 rtl/irq_prio.sv | 27 ++
 rtl/trap_ctrl.sv | 148 ++++++++++++++
 tb/tb_trap_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR layouts, cause codes and privilege encodings, plus trap sequencer types.
package csr_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [63:0] MCAUSE_INTERRUPT_MASK = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MCAUSE_ILLEGAL_INSN   = 64'd2;
    localparam logic [63:0] MCAUSE_BREAKPOINT     = 64'd3;
    localparam logic [63:0] MCAUSE_ECALL_U        = 64'd8;
    localparam logic [63:0] MCAUSE_ECALL_M        = 64'd11;
    localparam logic [63:0] MCAUSE_MSI            = 64'd3;
    localparam logic [63:0] MCAUSE_MTI            = 64'd7;
    localparam logic [63:0] MCAUSE_MEI            = 64'd11;

    typedef struct packed {
        logic [50:0] rsvd_63_13;
        logic [1:0]  mpp;
        logic [2:0]  rsvd_10_8;
        logic        mpie;
        logic [2:0]  rsvd_6_4;
        logic        mie;
        logic [2:0]  rsvd_2_0;
    } mstatus_t;

    localparam int unsigned MIRQ_MSI = 3;
    localparam int unsigned MIRQ_MTI = 7;
    localparam int unsigned MIRQ_MEI = 11;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StCommit,
        StRedirect
    } trap_state_t;

    typedef struct packed {
        logic        is_mret;
        logic [63:0] epc;
        logic [63:0] cause;
        logic [63:0] tval;
    } trap_ctx_t;

endpackage

// File: rtl/irq_prio.sv
// Pending machine-interrupt encoder: MEI > MSI > MTI, all other bits ignored.
module irq_prio
    import csr_pkg::*;
(
    input  logic [63:0] i_pending,
    output logic        o_valid,
    output logic [3:0]  o_code
);

    logic w_unused;
    assign w_unused = ^{i_pending[63:12], i_pending[10:8], i_pending[6:4], i_pending[2:0]};

    always_comb begin
        o_valid = 1'b1;
        o_code  = 4'd0;
        if (i_pending[MIRQ_MEI]) begin
            o_code = 4'(MIRQ_MEI);
        end else if (i_pending[MIRQ_MSI]) begin
            o_code = 4'(MIRQ_MSI);
        end else if (i_pending[MIRQ_MTI]) begin
            o_code = 4'(MIRQ_MTI);
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drain, CSR update, privilege update, fetch redirect.
// Optional TRAP_VECTORED_EN enables vectored interrupt targets when mtvec mode is 01.
module trap_ctrl
    import csr_pkg::*;
#(
    parameter logic [1:0] RESET_PRIV = PRIV_M
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_valid,
    input  logic [63:0] exc_cause,
    input  logic [63:0] exc_pc,
    input  logic [63:0] exc_tval,
    input  logic        mret_valid,
    input  logic        int_ok,
    input  logic [63:0] next_pc,
    input  logic        pipe_empty,
    input  logic [63:0] mstatus,
    input  logic [63:0] mie,
    input  logic [63:0] mip,
    input  logic [63:0] mtvec,
    input  logic [63:0] mepc,
    output logic        busy,
    output logic        flush,
    output logic [3:0]  csr_we,
    output logic [63:0] mepc_wdata,
    output logic [63:0] mcause_wdata,
    output logic [63:0] mtval_wdata,
    output logic [63:0] mstatus_wdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [1:0]  priv
);

    trap_state_t r_state, w_state_next;
    trap_ctx_t   r_ctx, w_ctx_next;
    logic [1:0]  r_priv, w_priv_next;
    mstatus_t    w_ms_in, w_ms_out;
    logic        w_irq_valid, w_irq_take;
    logic [3:0]  w_irq_code;
    logic [63:0] w_trap_base, w_trap_target;

    assign w_ms_in     = mstatus_t'(mstatus);
    assign w_trap_base = {mtvec[63:2], 2'b00};
    assign priv        = r_priv;

    irq_prio u_irq_prio (
        .i_pending (mip & mie),
        .o_valid   (w_irq_valid),
        .o_code    (w_irq_code)
    );

    // Interrupts are globally enabled below M, or in M only when mstatus.mie is set.
    assign w_irq_take = int_ok && w_irq_valid && ((r_priv != PRIV_M) || w_ms_in.mie);

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (mtvec[1:0] == 2'b01 && r_ctx.cause[63]) ?
                           w_trap_base + {58'd0, r_ctx.cause[3:0], 2'b00} : w_trap_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
    assign w_trap_target = w_trap_base;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_ctx   <= '0;
            r_priv  <= RESET_PRIV;
        end else begin
            r_state <= w_state_next;
            r_ctx   <= w_ctx_next;
            r_priv  <= w_priv_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctx_next   = r_ctx;
        w_priv_next  = r_priv;
        unique case (r_state)
            StIdle: begin
                if (exc_valid) begin
                    w_ctx_next   = '{is_mret: 1'b0, epc: exc_pc, cause: exc_cause, tval: exc_tval};
                    w_state_next = StDrain;
                end else if (mret_valid) begin
                    w_ctx_next   = '{is_mret: 1'b1, epc: '0, cause: '0, tval: '0};
                    w_state_next = StDrain;
                end else if (w_irq_take) begin
                    w_ctx_next   = '{is_mret: 1'b0, epc: next_pc,
                                     cause: MCAUSE_INTERRUPT_MASK | {60'd0, w_irq_code},
                                     tval: '0};
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: begin
                w_state_next = StRedirect;
                w_priv_next  = r_ctx.is_mret ? w_ms_in.mpp : PRIV_M;
            end
            StRedirect: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        busy           = (r_state != StIdle);
        flush          = busy;
        csr_we         = 4'b0000;
        mepc_wdata     = '0;
        mcause_wdata   = '0;
        mtval_wdata    = '0;
        mstatus_wdata  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_ms_out       = w_ms_in;
        if (r_state == StCommit) begin
            if (r_ctx.is_mret) begin
                csr_we        = 4'b1000;
                w_ms_out.mie  = w_ms_in.mpie;
                w_ms_out.mpie = 1'b1;
                w_ms_out.mpp  = PRIV_U;
            end else begin
                csr_we        = 4'b1111;
                mepc_wdata    = r_ctx.epc;
                mcause_wdata  = r_ctx.cause;
                mtval_wdata   = r_ctx.tval;
                w_ms_out.mpie = w_ms_in.mie;
                w_ms_out.mie  = 1'b0;
                w_ms_out.mpp  = r_priv;
            end
            mstatus_wdata = w_ms_out;
        end
        if (r_state == StRedirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = r_ctx.is_mret ? mepc : w_trap_target;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events against a model.
module tb_trap_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exc_valid, mret_valid, int_ok, pipe_empty;
    logic [63:0] exc_cause, exc_pc, exc_tval, next_pc;
    logic [63:0] mstatus, mie, mip, mtvec, mepc;
    logic        busy, flush, redirect_valid;
    logic [3:0]  csr_we;
    logic [63:0] mepc_wdata, mcause_wdata, mtval_wdata, mstatus_wdata, redirect_pc;
    logic [1:0]  priv;

    trap_ctrl #(.RESET_PRIV(PRIV_M)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .int_ok         (int_ok),
        .next_pc        (next_pc),
        .pipe_empty     (pipe_empty),
        .mstatus        (mstatus),
        .mie            (mie),
        .mip            (mip),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .busy           (busy),
        .flush          (flush),
        .csr_we         (csr_we),
        .mepc_wdata     (mepc_wdata),
        .mcause_wdata   (mcause_wdata),
        .mtval_wdata    (mtval_wdata),
        .mstatus_wdata  (mstatus_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .priv           (priv)
    );

    always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] m_priv;

    // Observations collected across one trap/mret sequence.
    int          obs_drain, obs_flush_bad;
    logic [3:0]  obs_we, obs_we_r;
    logic [63:0] obs_mepc, obs_mcause, obs_mtval, obs_ms, obs_rpc;
    logic        obs_flush_c, obs_flush_r, obs_rv, obs_busy_after, obs_rv_after;
    logic [1:0]  obs_priv_c, obs_priv_r;

    function automatic logic [63:0] m_trap_mstatus(input logic [63:0] ms, input logic [1:0] p);
        logic [63:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = p;
        return r;
    endfunction

    function automatic logic [63:0] m_mret_mstatus(input logic [63:0] ms);
        logic [63:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    function automatic int m_irq_code(input logic [63:0] pend);
        int order [3] = '{11, 3, 7};
        for (int i = 0; i < 3; i++) begin
            if (pend[order[i]]) return order[i];
        end
        return -1;
    endfunction

    function automatic logic [63:0] m_target(input logic [63:0] tvec, input bit is_irq,
                                             input int code);
        logic [63:0] t;
        t = tvec & ~64'h3;
        if (VEC_EN && is_irq && tvec[1:0] == 2'b01) t = t + 64'(4 * code);
        return t;
    endfunction

    task automatic idle_inputs();
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        int_ok     = 1'b0;
        pipe_empty = 1'b1;
        exc_cause  = '0;
        exc_pc     = '0;
        exc_tval   = '0;
        next_pc    = '0;
        mip        = '0;
        mie        = '0;
    endtask

    // Event inputs are already driven in IDLE; walk the sequence and record what the DUT shows.
    task automatic run_event(input int hold, input bit noise, output bit ok);
        ok            = 1'b1;
        obs_drain     = 0;
        obs_flush_bad = 0;
        @(posedge clk); #1;
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        int_ok     = 1'b0;
        while (csr_we === 4'b0000 && obs_drain < 40) begin
            if (flush !== 1'b1 || busy !== 1'b1) obs_flush_bad++;
            pipe_empty = (obs_drain >= hold);
            if (noise) begin
                exc_valid  = 1'($urandom_range(0, 1));
                mret_valid = 1'($urandom_range(0, 1));
                int_ok     = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            obs_drain++;
        end
        if (obs_drain >= 40) ok = 1'b0;
        obs_we      = csr_we;
        obs_mepc    = mepc_wdata;
        obs_mcause  = mcause_wdata;
        obs_mtval   = mtval_wdata;
        obs_ms      = mstatus_wdata;
        obs_flush_c = flush;
        obs_priv_c  = priv;
        exc_valid   = 1'b0;
        mret_valid  = 1'b0;
        int_ok      = 1'b0;
        @(posedge clk); #1;
        obs_rv      = redirect_valid;
        obs_rpc     = redirect_pc;
        obs_priv_r  = priv;
        obs_flush_r = flush;
        obs_we_r    = csr_we;
        @(posedge clk); #1;
        obs_busy_after = busy;
        obs_rv_after   = redirect_valid;
    endtask

    task automatic test_reset();
        idle_inputs();
        mstatus = '0; mtvec = '0; mepc = '0;
        reset_n = 1'b0;
        #12;
        checks++; if (priv !== PRIV_M) begin errors++; $display("FAIL reset_priv: got %0h want %0h", priv, PRIV_M); end
        checks++; if ({busy, flush, redirect_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got busy/flush/rv %b want 000", {busy, flush, redirect_valid}); end
        checks++; if (csr_we !== 4'b0000) begin errors++; $display("FAIL reset_we: got %b want 0000", csr_we); end
        checks++; if ((mepc_wdata | mcause_wdata | mtval_wdata | mstatus_wdata | redirect_pc) !== 64'd0) begin errors++; $display("FAIL reset_data: some output data nonzero"); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_priv  = PRIV_M;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_mret_to_u();
        bit ok;
        idle_inputs();
        mstatus    = 64'h0000_000A_0000_0080;
        mepc       = 64'h8000_0200;
        mret_valid = 1'b1;
        run_event(0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mret_timeout: got no COMMIT want COMMIT"); end
        checks++; if (obs_we !== 4'b1000) begin errors++; $display("FAIL mret_we: got %b want 1000", obs_we); end
        checks++; if (obs_ms !== 64'h0000_000A_0000_0088) begin errors++; $display("FAIL mret_mstatus: got %h want %h", obs_ms, 64'h0000_000A_0000_0088); end
        checks++; if (obs_priv_r !== PRIV_U) begin errors++; $display("FAIL mret_priv: got %0h want %0h", obs_priv_r, PRIV_U); end
        checks++; if (obs_rv !== 1'b1 || obs_rpc !== 64'h8000_0200) begin errors++; $display("FAIL mret_redirect: got rv=%b pc=%h want rv=1 pc=80000200", obs_rv, obs_rpc); end
        m_priv = PRIV_U;
    endtask

    task automatic test_ecall_from_u();
        bit ok;
        idle_inputs();
        mstatus   = 64'h0000_000A_0000_0008;
        mtvec     = 64'h8000_1000;
        exc_valid = 1'b1;
        exc_cause = 64'd8;
        exc_pc    = 64'h8000_0010;
        run_event(0, 1'b0, ok);
        checks++; if (!ok || obs_drain != 1) begin errors++; $display("FAIL ecall_latency: got drain=%0d want 1", obs_drain); end
        checks++; if (obs_we !== 4'b1111) begin errors++; $display("FAIL ecall_we: got %b want 1111", obs_we); end
        checks++; if (obs_mepc !== 64'h8000_0010 || obs_mcause !== 64'd8) begin errors++; $display("FAIL ecall_epc_cause: got %h/%h want 80000010/8", obs_mepc, obs_mcause); end
        checks++; if (obs_ms !== 64'h0000_000A_0000_0080) begin errors++; $display("FAIL ecall_mstatus: got %h want %h", obs_ms, 64'h0000_000A_0000_0080); end
        checks++; if (obs_priv_c !== PRIV_U || obs_priv_r !== PRIV_M) begin errors++; $display("FAIL ecall_priv: got commit=%0h redirect=%0h want 0/3", obs_priv_c, obs_priv_r); end
        checks++; if (obs_rv !== 1'b1 || obs_rpc !== 64'h8000_1000) begin errors++; $display("FAIL ecall_redirect: got rv=%b pc=%h want rv=1 pc=80001000", obs_rv, obs_rpc); end
        checks++; if (obs_busy_after !== 1'b0 || obs_rv_after !== 1'b0) begin errors++; $display("FAIL ecall_idle: got busy=%b rv=%b want 0/0", obs_busy_after, obs_rv_after); end
        m_priv = PRIV_M;
    endtask

    task automatic test_vectored_irq();
        bit ok;
        logic [63:0] want_pc;
        idle_inputs();
        mstatus = 64'h8;
        mtvec   = 64'h8000_1001;
        mip     = 64'h80;
        mie     = 64'h80;
        next_pc = 64'h8000_0100;
        int_ok  = 1'b1;
        want_pc = VEC_EN ? 64'h8000_101C : 64'h8000_1000;
        run_event(0, 1'b0, ok);
        checks++; if (!ok || obs_mcause !== 64'h8000_0000_0000_0007) begin errors++; $display("FAIL vec_cause: got %h want 8000000000000007", obs_mcause); end
        checks++; if (obs_mtval !== 64'd0 || obs_mepc !== 64'h8000_0100) begin errors++; $display("FAIL vec_tval_epc: got %h/%h want 0/80000100", obs_mtval, obs_mepc); end
        checks++; if (obs_ms !== 64'h1880) begin errors++; $display("FAIL vec_mstatus: got %h want 1880", obs_ms); end
        checks++; if (obs_rpc !== want_pc) begin errors++; $display("FAIL vec_redirect: got %h want %h", obs_rpc, want_pc); end
        m_priv = PRIV_M;
    endtask

    task automatic test_irq_priority();
        bit ok;
        idle_inputs();
        mstatus = 64'h8;
        mtvec   = 64'h8000_2000;
        mip     = 64'h888;
        mie     = 64'h888;
        int_ok  = 1'b1;
        run_event(1, 1'b0, ok);
        checks++; if (!ok || obs_mcause !== 64'h8000_0000_0000_000B) begin errors++; $display("FAIL prio_mei: got %h want 800000000000000b", obs_mcause); end
        checks++; if (obs_drain != 2) begin errors++; $display("FAIL prio_drain: got %0d want 2", obs_drain); end
        idle_inputs();
        mip = 64'h888; mie = 64'h888; int_ok = 1'b1;
        exc_valid = 1'b1; exc_cause = 64'd2; exc_pc = 64'h8000_0300; exc_tval = 64'hDEAD;
        run_event(0, 1'b0, ok);
        checks++; if (!ok || obs_mcause !== 64'd2) begin errors++; $display("FAIL prio_exc_wins: got %h want 2", obs_mcause); end
        checks++; if (obs_mepc !== 64'h8000_0300 || obs_mtval !== 64'hDEAD) begin errors++; $display("FAIL prio_exc_ctx: got %h/%h want 80000300/dead", obs_mepc, obs_mtval); end
        // M-mode with mstatus.mie clear must not take the interrupt.
        idle_inputs();
        mstatus = 64'h0; mip = 64'h80; mie = 64'h80; int_ok = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_masked: got busy=%b want 0", busy); end
        mstatus = 64'h8; int_ok = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_no_intok: got busy=%b want 0", busy); end
        idle_inputs();
    endtask

    task automatic test_drain_reset();
        bit ok;
        idle_inputs();
        mstatus    = 64'h80;
        mepc       = 64'h8000_0400;
        mret_valid = 1'b1;
        run_event(0, 1'b0, ok);
        checks++; if (!ok || priv !== PRIV_U) begin errors++; $display("FAIL drain_setup_priv: got %0h want 0", priv); end
        idle_inputs();
        exc_valid = 1'b1; exc_cause = 64'd8; exc_pc = 64'h8000_0500;
        @(posedge clk); #1;
        exc_valid  = 1'b0;
        pipe_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (flush !== 1'b1 || busy !== 1'b1 || csr_we !== 4'b0000) begin errors++; $display("FAIL drain_hold%0d: got flush=%b busy=%b we=%b want 1/1/0000", i, flush, busy, csr_we); end
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, flush, redirect_valid} !== 3'b000 || csr_we !== 4'b0000) begin errors++; $display("FAIL drain_reset_ctrl: got busy/flush/rv=%b we=%b want 000/0000", {busy, flush, redirect_valid}, csr_we); end
        checks++; if (priv !== PRIV_M) begin errors++; $display("FAIL drain_reset_priv: got %0h want 3", priv); end
        @(posedge clk); #1;
        pipe_empty = 1'b1;
        reset_n    = 1'b1;
        m_priv     = PRIV_M;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0 || csr_we !== 4'b0000 || redirect_valid !== 1'b0) begin errors++; $display("FAIL post_reset_quiet%0d: got busy=%b we=%b rv=%b want 0", i, busy, csr_we, redirect_valid); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int code, kind, hold;
        logic [3:0]  e_we;
        logic [63:0] e_epc, e_cause, e_tval, e_ms, e_pc;
        logic [1:0]  e_priv;
        for (int it = 0; it < 40; it++) begin
            idle_inputs();
            exc_valid  = ($urandom_range(0, 3) == 0);
            mret_valid = ($urandom_range(0, 3) == 0);
            int_ok     = 1'($urandom_range(0, 1));
            exc_cause  = 64'($urandom_range(0, 15));
            exc_pc     = {$urandom, $urandom};
            exc_tval   = {$urandom, $urandom};
            next_pc    = {$urandom, $urandom};
            mip        = 64'($urandom_range(0, 4095));
            mie        = 64'($urandom_range(0, 4095));
            mstatus    = {$urandom, $urandom};
            mtvec      = {$urandom, $urandom};
            mepc       = {$urandom, $urandom};
            hold       = $urandom_range(0, 3);
            code       = m_irq_code(mip & mie);
            if (exc_valid) kind = 1;
            else if (mret_valid) kind = 2;
            else if (int_ok && code >= 0 && (m_priv != PRIV_M || mstatus[3])) kind = 3;
            else kind = 0;
            if (kind == 0) begin
                @(posedge clk); #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_spurious: got busy=%b want 0", it, busy); end
                idle_inputs();
                for (int w = 0; w < 50 && busy === 1'b1; w++) begin @(posedge clk); #1; end
                continue;
            end
            if (kind == 2) begin
                e_we = 4'b1000; e_ms = m_mret_mstatus(mstatus); e_priv = mstatus[12:11]; e_pc = mepc;
                e_epc = '0; e_cause = '0; e_tval = '0;
            end else begin
                e_we   = 4'b1111;
                e_ms   = m_trap_mstatus(mstatus, m_priv);
                e_priv = PRIV_M;
                e_pc   = m_target(mtvec, kind == 3, code);
                e_epc   = (kind == 1) ? exc_pc : next_pc;
                e_cause = (kind == 1) ? exc_cause : (64'h8000_0000_0000_0000 | 64'(code));
                e_tval  = (kind == 1) ? exc_tval : 64'd0;
            end
            run_event(hold, 1'b1, ok);
            checks++; if (!ok || obs_drain != hold + 1 || obs_flush_bad != 0) begin errors++; $display("FAIL rnd%0d_drain: got drain=%0d bad=%0d want %0d/0", it, obs_drain, obs_flush_bad, hold + 1); end
            checks++; if (obs_we !== e_we || obs_flush_c !== 1'b1) begin errors++; $display("FAIL rnd%0d_we: got %b flush=%b want %b flush=1", it, obs_we, obs_flush_c, e_we); end
            checks++; if (obs_ms !== e_ms) begin errors++; $display("FAIL rnd%0d_mstatus: got %h want %h", it, obs_ms, e_ms); end
            if (kind != 2) begin
                checks++; if (obs_mepc !== e_epc || obs_mcause !== e_cause || obs_mtval !== e_tval) begin errors++; $display("FAIL rnd%0d_ctx: got %h/%h/%h want %h/%h/%h", it, obs_mepc, obs_mcause, obs_mtval, e_epc, e_cause, e_tval); end
            end
            checks++; if (obs_priv_c !== m_priv || obs_priv_r !== e_priv) begin errors++; $display("FAIL rnd%0d_priv: got %0h->%0h want %0h->%0h", it, obs_priv_c, obs_priv_r, m_priv, e_priv); end
            checks++; if (obs_rv !== 1'b1 || obs_rpc !== e_pc || obs_we_r !== 4'b0000 || obs_flush_r !== 1'b1) begin errors++; $display("FAIL rnd%0d_redirect: got rv=%b pc=%h we=%b want rv=1 pc=%h we=0000", it, obs_rv, obs_rpc, obs_we_r, e_pc); end
            checks++; if (obs_busy_after !== 1'b0 || obs_rv_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got busy=%b rv=%b want 0/0", it, obs_busy_after, obs_rv_after); end
            m_priv = e_priv;
        end
    endtask

    initial begin
        test_reset();
        test_mret_to_u();
        test_ecall_from_u();
        test_vectored_irq();
        test_irq_priority();
        test_drain_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
